// File: rtl/spi_note_receiver.sv
// -----------------------------------------------------------------------------
// spi_note_receiver
//
// Purpose: receives 3-byte note packets over a mode-0 SPI link that runs
// asynchronously to clk, validates them and hands the decoded fields to the
// voice controller with a one-clk ready pulse. A field error sends the FSM to
// DROP, which ignores every further sclk edge until cs_n rises. A frame that
// ends mid-packet is also rejected. frame_err pulses once per rejected packet,
// and err_count counts rejections, saturating at 255.
//
// Packet layout (MSB first):
//   byte0 = voice_index[7:0]
//   byte1 = {note_status, midi_note[6:0]}
//   byte2 = {1'b0, velocity[6:0]}
// Packets may follow back to back inside one cs_n frame.
//
// Optional feature macro: SPI_MISO_ECHO_EN
//   defined   -> miso echoes the previously received byte, MSB first, with
//                one byte of lag. It changes on sclk falling edges.
//   undefined -> miso is tied to 0 and no echo register exists.
//
// Parameters:
//   SYNC_STAGES  synchronizer depth for sclk/mosi/cs_n (2..4)
//   MAX_VOICE    voice indices >= MAX_VOICE are rejected
//
// Ports:
//   clk              system clock (must be at least 8x sclk)
//   reset            asynchronous active-high reset
//   sclk, mosi, cs_n SPI inputs, asynchronous to clk
//   miso             SPI data out (echo or constant 0)
//   SPI_note_status, SPI_voice_index, SPI_midi_note, SPI_velocity
//                    fields of the last accepted packet
//   SPI_ready_flag   one-clk pulse: new fields are valid
//   frame_err        one-clk pulse per rejected packet
//   err_count        saturating count of rejected packets
// -----------------------------------------------------------------------------
module spi_note_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_VOICE   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       cs_n,
    output logic       miso,
    output logic       SPI_note_status,
    output logic [7:0] SPI_voice_index,
    output logic [6:0] SPI_midi_note,
    output logic [6:0] SPI_velocity,
    output logic       SPI_ready_flag,
    output logic       frame_err,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;

    logic [2:0] bit_cnt_q;
    logic [1:0] byte_cnt_q;
    logic [7:0] shift_q;
    logic [7:0] voice_q;
    logic [7:0] byte1_q;

    logic       note_status_q;
    logic [7:0] voice_index_q;
    logic [6:0] midi_note_q;
    logic [6:0] velocity_q;
    logic       ready_q;
    logic       frame_err_q;
    logic [7:0] err_cnt_q;

    logic       sclk_s;
    logic       mosi_s;
    logic       cs_s;
    logic       sclk_rise_s;
    logic       cs_fall_s;
    logic       cs_rise_s;
    logic       recv_s;
    logic [7:0] shift_d;
    logic [2:0] bit_cnt_d;
    logic [1:0] byte_cnt_d;
    logic       byte_done_s;
    logic       pkt_done_s;
    logic       pkt_ok_s;
    logic       pkt_bad_s;
    logic       cs_err_s;
    logic       err_s;

    // Synchronizer chains plus one delayed copy of sclk/cs_n for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= {SYNC_STAGES{1'b0}};
            mosi_sync_q <= {SYNC_STAGES{1'b0}};
            cs_sync_q   <= {SYNC_STAGES{1'b1}};
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    // Edge detection, next counter values and packet/frame error decisions.
    always_comb begin
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        cs_s        = cs_sync_q[SYNC_STAGES-1];
        sclk_rise_s = sclk_s & ~sclk_prev_q;
        cs_fall_s   = cs_prev_q & ~cs_s;
        cs_rise_s   = ~cs_prev_q & cs_s;
        recv_s      = (state_q == ST_RECV);
        shift_d     = {shift_q[6:0], mosi_s};
        byte_done_s = recv_s & sclk_rise_s & (bit_cnt_q == 3'd7);
        pkt_done_s  = byte_done_s & (byte_cnt_q == 2'd2);
        pkt_ok_s    = pkt_done_s & (int'(voice_q) < MAX_VOICE) & ~shift_d[7];
        pkt_bad_s   = pkt_done_s & ~pkt_ok_s;

        if (recv_s && sclk_rise_s) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
        end else begin
            bit_cnt_d = bit_cnt_q;
        end

        if (byte_done_s) begin
            if (byte_cnt_q >= 2'd2) begin
                byte_cnt_d = 2'd0;
            end else begin
                byte_cnt_d = byte_cnt_q + 2'd1;
            end
        end else begin
            byte_cnt_d = byte_cnt_q;
        end

        // Judged on the post-edge counters, so a packet that completes in the
        // same clk as the cs_n rise counts as a clean boundary.
        cs_err_s = recv_s & cs_rise_s & ((bit_cnt_d != 3'd0) | (byte_cnt_d != 2'd0));
        err_s    = pkt_bad_s | cs_err_s;
    end

    // Main FSM: receive counters, field capture, pulses and error counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 3'd0;
            byte_cnt_q    <= 2'd0;
            shift_q       <= 8'd0;
            voice_q       <= 8'd0;
            byte1_q       <= 8'd0;
            note_status_q <= 1'b0;
            voice_index_q <= 8'd0;
            midi_note_q   <= 7'd0;
            velocity_q    <= 7'd0;
            ready_q       <= 1'b0;
            frame_err_q   <= 1'b0;
            err_cnt_q     <= 8'd0;
        end else begin
            ready_q     <= pkt_ok_s;
            frame_err_q <= err_s;
            if (err_s && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
            if (pkt_ok_s) begin
                voice_index_q <= voice_q;
                note_status_q <= byte1_q[7];
                midi_note_q   <= byte1_q[6:0];
                velocity_q    <= shift_d[6:0];
            end

            case (state_q)
                ST_IDLE: begin
                    bit_cnt_q  <= 3'd0;
                    byte_cnt_q <= 2'd0;
                    if (cs_fall_s) begin
                        state_q <= ST_RECV;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RECV: begin
                    bit_cnt_q  <= bit_cnt_d;
                    byte_cnt_q <= byte_cnt_d;
                    if (sclk_rise_s) begin
                        shift_q <= shift_d;
                    end
                    if (byte_done_s && (byte_cnt_q == 2'd0)) begin
                        voice_q <= shift_d;
                    end
                    if (byte_done_s && (byte_cnt_q == 2'd1)) begin
                        byte1_q <= shift_d;
                    end
                    if (cs_rise_s) begin
                        state_q <= ST_IDLE;
                    end else if (pkt_bad_s) begin
                        state_q <= ST_DROP;
                    end else begin
                        state_q <= ST_RECV;
                    end
                end
                ST_DROP: begin
                    if (cs_rise_s) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_DROP;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SPI_MISO_ECHO_EN
    logic       sclk_fall_s;
    logic [7:0] hold_q;
    logic [7:0] echo_q;
    logic       reload_q;
    logic       miso_q;

    // Falling edge of the synchronized sclk: when the echo bit changes.
    always_comb begin
        sclk_fall_s = ~sclk_s & sclk_prev_q;
    end

    // Echo shifter. A completed byte is parked in hold_q and goes out on the
    // next falling edge, so its MSB is valid before the host samples it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q   <= 8'd0;
            echo_q   <= 8'd0;
            reload_q <= 1'b0;
            miso_q   <= 1'b0;
        end else if (byte_done_s) begin
            hold_q   <= shift_d;
            reload_q <= 1'b1;
        end else if (recv_s && sclk_fall_s) begin
            if (reload_q) begin
                miso_q   <= hold_q[7];
                echo_q   <= {hold_q[6:0], 1'b0};
                reload_q <= 1'b0;
            end else begin
                miso_q <= echo_q[7];
                echo_q <= {echo_q[6:0], 1'b0};
            end
        end
    end

    assign miso = miso_q;
`else
    assign miso = 1'b0;
`endif

    assign SPI_note_status = note_status_q;
    assign SPI_voice_index = voice_index_q;
    assign SPI_midi_note   = midi_note_q;
    assign SPI_velocity    = velocity_q;
    assign SPI_ready_flag  = ready_q;
    assign frame_err       = frame_err_q;
    assign err_count       = err_cnt_q;

endmodule
